// File: rtl/cpu_rd_pkg.sv
// rtl/cpu_rd_pkg.sv - shared types and defaults for the CPU read-back port
package cpu_rd_pkg;

    localparam int DEF_DW = 8;
    localparam int DEF_AW = 3;

    typedef enum logic [1:0] {
        ARMWAIT,
        IDLE,
        HOLD,
        DONE
    } state_t;

endpackage

// File: rtl/sync_nff.sv
// rtl/sync_nff.sv - N-flop synchroniser, preset to 1 so idle-high strobes read inactive
module sync_nff #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/cpu_rd_mux_sync.sv
// rtl/cpu_rd_mux_sync.sv - synchronised CPU register read-back with capture and clear-on-read strobe
module cpu_rd_mux_sync
    import cpu_rd_pkg::*;
#(
    parameter int               DW          = DEF_DW,
    parameter int               NREG        = 8,
    parameter int               AW          = DEF_AW,
    parameter int               SYNC_STAGES = 2,
    parameter logic [NREG-1:0]  RC_MASK     = '0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cs_n,
    input  logic                 oe_n,
    input  logic [AW-1:0]        addr,
    input  logic [NREG*DW-1:0]   reg_bus,
    output logic [DW-1:0]        data_out,
    output logic                 data_oe,
    output logic [NREG-1:0]      rd_pulse,
    output logic                 rd_err
);

    localparam int              CW       = $clog2(SYNC_STAGES + 1);
    localparam logic [CW-1:0]   ARM_FULL = CW'(SYNC_STAGES);

    logic cs_s;
    logic oe_s;
    logic rd_act;

    state_t            state_q, state_d;
    logic [CW-1:0]     arm_q, arm_d;
    logic [AW-1:0]     addr_q, addr_d;
    logic [DW-1:0]     data_q, data_d;
    logic              oe_q, oe_d;
    logic              err_q, err_d;
    logic [NREG-1:0]   pulse_q, pulse_d;

    sync_nff #(.STAGES(SYNC_STAGES)) u_sync_cs (
        .clk (clk),
        .rst (rst),
        .d_i (cs_n),
        .q_o (cs_s)
    );

    sync_nff #(.STAGES(SYNC_STAGES)) u_sync_oe (
        .clk (clk),
        .rst (rst),
        .d_i (oe_n),
        .q_o (oe_s)
    );

    assign rd_act = ~cs_s & ~oe_s;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ARMWAIT;
            arm_q   <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            oe_q    <= 1'b0;
            err_q   <= 1'b0;
            pulse_q <= '0;
        end else begin
            state_q <= state_d;
            arm_q   <= arm_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            oe_q    <= oe_d;
            err_q   <= err_d;
            pulse_q <= pulse_d;
        end
    end

    always_comb begin
        state_d = state_q;
        arm_d   = arm_q;
        addr_d  = addr_q;
        data_d  = data_q;
        oe_d    = oe_q;
        err_d   = err_q;
        pulse_d = '0;
        case (state_q)
            // The preset synchronisers read idle until the pins have propagated,
            // so the strobes are only trusted once the pipeline has filled.
            ARMWAIT: begin
                if (arm_q != ARM_FULL) begin
                    arm_d = arm_q + 1'b1;
                end else if (!rd_act) begin
                    state_d = IDLE;
                end
            end
            IDLE: begin
                if (rd_act) begin
                    addr_d = addr;
                    data_d = '0;
                    err_d  = 1'b1;
                    for (int i = 0; i < NREG; i++) begin
                        if (addr == AW'(i)) begin
                            data_d = reg_bus[i*DW +: DW];
                            err_d  = 1'b0;
                        end
                    end
                    oe_d    = 1'b1;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (!rd_act) begin
                    oe_d   = 1'b0;
                    data_d = '0;
                    err_d  = 1'b0;
                    for (int i = 0; i < NREG; i++) begin
                        if (addr_q == AW'(i) && RC_MASK[i]) begin
                            pulse_d[i] = 1'b1;
                        end
                    end
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = ARMWAIT;
            end
        endcase
    end

    assign data_out = data_q;
    assign data_oe  = oe_q;
    assign rd_err   = err_q;
    assign rd_pulse = pulse_q;

endmodule

// File: tb/tb_cpu_rd_mux_sync.sv
// tb/tb_cpu_rd_mux_sync.sv - directed vector bench for cpu_rd_mux_sync
module tb_cpu_rd_mux_sync;

    logic         clk = 1'b0;
    logic         rst;
    logic         cs_n;
    logic         oe_n;
    logic [2:0]   addr;
    logic [47:0]  reg_bus;
    logic [7:0]   data_out;
    logic         data_oe;
    logic [5:0]   rd_pulse;
    logic         rd_err;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    cpu_rd_mux_sync #(
        .DW          (8),
        .NREG        (6),
        .AW          (3),
        .SYNC_STAGES (2),
        .RC_MASK     (6'h04)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .cs_n     (cs_n),
        .oe_n     (oe_n),
        .addr     (addr),
        .reg_bus  (reg_bus),
        .data_out (data_out),
        .data_oe  (data_oe),
        .rd_pulse (rd_pulse),
        .rd_err   (rd_err)
    );

    typedef struct {
        logic [2:0] a;
        logic [7:0] val;
        int         order;
        logic [7:0] ed;
        logic       ee;
        logic [5:0] ep;
    } vec_t;

    vec_t vt[10];

    task automatic chk(input string nm, input int tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s[%0d]: got %0h expected %0h", nm, tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_reg(input int idx, input logic [7:0] v);
        reg_bus[idx*8 +: 8] = v;
    endtask

    // order 0: both strobes released together, 1: oe_n first, 2: cs_n first
    task automatic access(input int tag, input logic [2:0] a, input int order,
                          input logic [7:0] ed, input logic ee, input logic [5:0] ep);
        @(negedge clk);
        addr = a;
        cs_n = 1'b0;
        oe_n = 1'b0;
        tick();
        tick();
        chk("oe_early", tag, 32'(data_oe), 32'd0);
        tick();
        chk("oe_rise", tag, 32'(data_oe), 32'd1);
        chk("data", tag, 32'(data_out), 32'(ed));
        chk("err", tag, 32'(rd_err), 32'(ee));
        chk("pulse_hold", tag, 32'(rd_pulse), 32'd0);
        repeat (5) tick();
        chk("data_held", tag, 32'(data_out), 32'(ed));
        @(negedge clk);
        case (order)
            1:       oe_n = 1'b1;
            2:       cs_n = 1'b1;
            default: begin cs_n = 1'b1; oe_n = 1'b1; end
        endcase
        tick();
        cs_n = 1'b1;
        oe_n = 1'b1;
        tick();
        chk("oe_fall_early", tag, 32'(data_oe), 32'd1);
        tick();
        chk("oe_fall", tag, 32'(data_oe), 32'd0);
        chk("data_done", tag, 32'(data_out), 32'd0);
        chk("err_done", tag, 32'(rd_err), 32'd0);
        chk("pulse", tag, 32'(rd_pulse), 32'(ep));
        tick();
        chk("pulse_one", tag, 32'(rd_pulse), 32'd0);
        repeat (4) tick();
    endtask

    initial begin
        vt[0] = '{3'd3, 8'hA5, 0, 8'hA5, 1'b0, 6'h00};
        vt[1] = '{3'd2, 8'h5A, 0, 8'h5A, 1'b0, 6'h04};
        vt[2] = '{3'd2, 8'h77, 0, 8'h77, 1'b0, 6'h04};
        vt[3] = '{3'd1, 8'hC3, 0, 8'hC3, 1'b0, 6'h00};
        vt[4] = '{3'd0, 8'h01, 0, 8'h01, 1'b0, 6'h00};
        vt[5] = '{3'd5, 8'hFF, 0, 8'hFF, 1'b0, 6'h00};
        vt[6] = '{3'd6, 8'h99, 0, 8'h00, 1'b1, 6'h00};
        vt[7] = '{3'd7, 8'h99, 0, 8'h00, 1'b1, 6'h00};
        vt[8] = '{3'd2, 8'h3E, 1, 8'h3E, 1'b0, 6'h04};
        vt[9] = '{3'd2, 8'hE3, 2, 8'hE3, 1'b0, 6'h04};

        rst     = 1'b0;
        cs_n    = 1'b1;
        oe_n    = 1'b1;
        addr    = 3'd0;
        reg_bus = 48'h665544332211;
        #1;
        chk("rst_data", 0, 32'(data_out), 32'd0);
        chk("rst_oe", 0, 32'(data_oe), 32'd0);
        chk("rst_pulse", 0, 32'(rd_pulse), 32'd0);
        chk("rst_err", 0, 32'(rd_err), 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (6) tick();

        for (int i = 0; i < 10; i++) begin
            if (vt[i].a < 3'd6) set_reg(int'(vt[i].a), vt[i].val);
            access(i, vt[i].a, vt[i].order, vt[i].ed, vt[i].ee, vt[i].ep);
        end

        // register and address change while the access is held
        set_reg(3, 8'hA5);
        @(negedge clk);
        addr = 3'd3;
        cs_n = 1'b0;
        oe_n = 1'b0;
        repeat (3) tick();
        chk("hold_oe", 20, 32'(data_oe), 32'd1);
        @(negedge clk);
        set_reg(3, 8'h3C);
        addr = 3'd5;
        repeat (3) tick();
        chk("hold_frozen", 20, 32'(data_out), 32'hA5);
        @(negedge clk);
        cs_n = 1'b1;
        oe_n = 1'b1;
        repeat (3) tick();
        chk("hold_done_oe", 20, 32'(data_oe), 32'd0);
        chk("hold_done_pulse", 20, 32'(rd_pulse), 32'd0);
        repeat (4) tick();

        // reset in HOLD with strobes kept asserted
        set_reg(2, 8'h42);
        @(negedge clk);
        addr = 3'd2;
        cs_n = 1'b0;
        oe_n = 1'b0;
        repeat (3) tick();
        chk("prerst_data", 30, 32'(data_out), 32'h42);
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk("arst_data", 30, 32'(data_out), 32'd0);
        chk("arst_oe", 30, 32'(data_oe), 32'd0);
        chk("arst_pulse", 30, 32'(rd_pulse), 32'd0);
        chk("arst_err", 30, 32'(rd_err), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        for (int c = 0; c < 10; c++) begin
            tick();
            chk("armwait_oe", 31 + c, 32'(data_oe), 32'd0);
            chk("armwait_pulse", 31 + c, 32'(rd_pulse), 32'd0);
        end
        @(negedge clk);
        cs_n = 1'b1;
        oe_n = 1'b1;
        repeat (5) tick();
        set_reg(2, 8'h24);
        access(50, 3'd2, 0, 8'h24, 1'b0, 6'h04);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
